// File: rtl/jtvigil_obj_pkg.sv
// Shared types for the object graphics ROM slot: FSM states and cache entry layout.
package jtvigil_obj_pkg;

  localparam int unsigned ROM_AW = 18;
  localparam int unsigned TAG_W  = ROM_AW - 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    W0,
    W1
  } obj_st_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } obj_entry_t;

endpackage

// File: rtl/jtvigil_obj_romcache.sv
// Tagged 32-bit store for object ROM data: combinational lookup, probe and single write port.
module jtvigil_obj_romcache
  import jtvigil_obj_pkg::*;
#(
  parameter int unsigned NE = 1
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             inv,
  input  logic             lk_en,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  output logic [31:0]      hit_data,
  input  logic [TAG_W-1:0] pb_tag,
  output logic             pb_hit,
  output logic             victim,
  input  logic             we,
  input  logic             widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic [31:0]      wdata
);

  obj_entry_t ent [NE];
  logic       mru;
  logic       found;
  logic       hit_idx;

  // Lookup for the drawer's address plus a presence probe for the prefetch tag
  always_comb begin
    found    = 1'b0;
    hit_idx  = 1'b0;
    hit_data = '0;
    pb_hit   = 1'b0;
    for (int i = 0; i < NE; i++) begin
      if (!found && ent[i].valid && ent[i].tag == lk_tag) begin
        found    = 1'b1;
        hit_idx  = 1'(i);
        hit_data = ent[i].data;
      end
      if (ent[i].valid && ent[i].tag == pb_tag) pb_hit = 1'b1;
    end
    hit = found && lk_en && !inv;
  end

  assign victim = (NE > 1) ? ~mru : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) ent[i] <= '0;
      mru <= 1'b0;
    end else begin
      if (inv) begin
        for (int i = 0; i < NE; i++) ent[i].valid <= 1'b0;
      end else if (we) begin
        for (int i = 0; i < NE; i++) begin
          if (widx == 1'(i)) ent[i] <= '{valid: 1'b1, tag: wtag, data: wdata};
        end
      end
      if (we) mru <= widx;
      else if (hit) mru <= hit_idx;
    end
  end

endmodule

// File: rtl/jtvigil_obj_romslot.sv
// Object graphics ROM responder: 32-bit requests served from a tagged cache, misses fetched as 2-beat SDRAM bursts.
// Define JTVIGIL_OBJ_PREFETCH_EN for a two-entry cache that prefetches the other hflip half-row.
module jtvigil_obj_romslot
  import jtvigil_obj_pkg::*;
#(
  parameter int unsigned   AW     = 22,
  parameter logic [AW-1:0] OFFSET = '0
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              inv,
  input  logic              rom_cs,
  input  logic [ROM_AW-1:0] rom_addr,
  output logic [31:0]       rom_data,
  output logic              rom_ok,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic              sdram_dst,
  input  logic [15:0]       sdram_din
);

`ifdef JTVIGIL_OBJ_PREFETCH_EN
  localparam int unsigned NE = 2;
  localparam logic        PF = 1'b1;
`else
  localparam int unsigned NE = 1;
  localparam logic        PF = 1'b0;
`endif

  obj_st_t          st, st_nx;
  logic [TAG_W-1:0] tgt, tgt_nx;
  logic [15:0]      lo, lo_nx;
  logic             discard, discard_nx;
  logic             is_pf, is_pf_nx;
  logic             pf_pend, pf_pend_nx;
  logic             widx, widx_nx;
  logic             req_nx;
  logic [AW-1:0]    addr_nx;
  logic             hit, pb_hit, victim, we;
  logic [TAG_W-1:0] cur_tag;
  logic             addr_lsb_unused;

  assign cur_tag         = rom_addr[ROM_AW-1:1];
  assign addr_lsb_unused = rom_addr[0];
  assign rom_ok          = hit;

  jtvigil_obj_romcache #(.NE(NE)) u_cache (
    .rst      (rst),
    .clk      (clk),
    .inv      (inv),
    .lk_en    (rom_cs),
    .lk_tag   (cur_tag),
    .hit      (hit),
    .hit_data (rom_data),
    .pb_tag   (tgt ^ TAG_W'(1)),
    .pb_hit   (pb_hit),
    .victim   (victim),
    .we       (we),
    .widx     (widx),
    .wtag     (tgt),
    .wdata    ({sdram_din, lo})
  );

  function automatic logic [AW-1:0] burst_addr(input logic [TAG_W-1:0] t);
    return AW'(OFFSET + AW'({t, 1'b0}));
  endfunction

  // Next-state: bursts always run to completion; inv anywhere in a burst discards its fill
  always_comb begin
    st_nx      = st;
    tgt_nx     = tgt;
    lo_nx      = lo;
    discard_nx = discard | inv;
    is_pf_nx   = is_pf;
    widx_nx    = widx;
    pf_pend_nx = pf_pend;
    req_nx     = sdram_req;
    addr_nx    = sdram_addr;
    we         = 1'b0;
    unique case (st)
      IDLE: begin
        discard_nx = 1'b0;
        pf_pend_nx = 1'b0;
        if (rom_cs && !inv) begin
          if (!hit) begin
            st_nx    = REQ;
            tgt_nx   = cur_tag;
            widx_nx  = victim;
            is_pf_nx = 1'b0;
            req_nx   = 1'b1;
            addr_nx  = burst_addr(cur_tag);
          end else if (PF && pf_pend && !pb_hit) begin
            st_nx    = REQ;
            tgt_nx   = tgt ^ TAG_W'(1);
            widx_nx  = ~widx;
            is_pf_nx = 1'b1;
            req_nx   = 1'b1;
            addr_nx  = burst_addr(tgt ^ TAG_W'(1));
          end
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_nx = 1'b0;
          if (sdram_dst) begin
            lo_nx = sdram_din;
            st_nx = W1;
          end else begin
            st_nx = W0;
          end
        end
      end
      W0: begin
        if (sdram_dst) begin
          lo_nx = sdram_din;
          st_nx = W1;
        end
      end
      W1: begin
        if (sdram_dst) begin
          we         = !discard && !inv;
          st_nx      = IDLE;
          pf_pend_nx = PF && !is_pf && we;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      tgt        <= '0;
      lo         <= '0;
      discard    <= 1'b0;
      is_pf      <= 1'b0;
      pf_pend    <= 1'b0;
      widx       <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      st         <= st_nx;
      tgt        <= tgt_nx;
      lo         <= lo_nx;
      discard    <= discard_nx;
      is_pf      <= is_pf_nx;
      pf_pend    <= pf_pend_nx;
      widx       <= widx_nx;
      sdram_req  <= req_nx;
      sdram_addr <= addr_nx;
    end
  end

endmodule

// File: tb/tb_jtvigil_obj_romslot.sv
// Self-checking bench for jtvigil_obj_romslot (default single-entry build, OFFSET=22'h10000).
module tb_jtvigil_obj_romslot;

  localparam int unsigned   AW  = 22;
  localparam logic [AW-1:0] OFF = 22'h10000;

  logic          rst, clk, inv, rom_cs;
  logic [17:0]   rom_addr;
  logic [31:0]   rom_data;
  logic          rom_ok;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack, sdram_dst;
  logic [15:0]   sdram_din;

  jtvigil_obj_romslot #(.AW(AW), .OFFSET(OFF)) dut (
    .rst        (rst),
    .clk        (clk),
    .inv        (inv),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_din  (sdram_din)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem(input logic [AW-1:0] a);
    logic [31:0] h;
    if (a == 22'h10404) return 16'hA1B2;
    if (a == 22'h10405) return 16'hC3D4;
    h = 32'(a) * 32'h9E3779B1;
    return h[31:16];
  endfunction

  // Memory responder with programmable ack delay and strobe spacing
  int            ack_dly = 1, d0 = 1, d1 = 1;
  logic          busy = 1'b0, bad = 1'b0, fill_now = 1'b0;
  logic [AW-1:0] req_log[$];
  int            req_cyc = 0;
  logic [16:0]   fill_tag;
  logic [31:0]   fill_data;

  task automatic step();
    @(posedge clk);
    if (inv || rst) bad = 1'b1;
    #1;
  endtask

  initial begin
    logic [AW-1:0] a;
    int ka, k0, k1;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_din = '0;
    forever begin
      @(posedge clk); #1;
      if (sdram_req) begin
        a = sdram_addr; req_log.push_back(a); req_cyc = cyc;
        bad = 1'b0; busy = 1'b1;
        ka = ack_dly; k0 = d0; k1 = d1;
        for (int k = 0; k < ka; k++) begin
          check("req_hold", 32'(sdram_req), 32'd1);
          check("addr_hold", 32'(sdram_addr), 32'(a));
          step();
        end
        sdram_ack = 1'b1;
        if (k0 == 0) begin sdram_dst = 1'b1; sdram_din = mem(a); end
        step();
        sdram_ack = 1'b0; sdram_dst = 1'b0;
        if (!rst) check("req_drop", 32'(sdram_req), 32'd0);
        if (k0 > 0) begin
          repeat (k0 - 1) step();
          sdram_dst = 1'b1; sdram_din = mem(a);
          step();
          sdram_dst = 1'b0;
        end
        repeat (k1 - 1) step();
        sdram_dst = 1'b1; sdram_din = mem(AW'(a + 1));
        fill_tag  = 17'((a - OFF) >> 1);
        fill_data = {mem(AW'(a + 1)), mem(a)};
        fill_now  = 1'b1;
        step();
        sdram_dst = 1'b0; fill_now = 1'b0; busy = 1'b0;
      end
    end
  end

  // Reference: one cached 32-bit row, filled by each clean burst, wiped by inv or reset
  logic        m_valid;
  logic [16:0] m_tag;
  logic [31:0] m_data;
  always @(posedge clk or posedge rst) begin
    if (rst)                    m_valid <= 1'b0;
    else if (inv)               m_valid <= 1'b0;
    else if (fill_now && !bad) begin
      m_valid <= 1'b1; m_tag <= fill_tag; m_data <= fill_data;
    end
  end

  logic mon_en = 1'b0;
  logic exp_ok;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      exp_ok = rom_cs && !inv && m_valid && (m_tag == rom_addr[17:1]);
      check("rom_ok", 32'(rom_ok), 32'(exp_ok));
      if (exp_ok) check("rom_data", rom_data, m_data);
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_req(input int n, input string name);
    for (int k = 0; k < 200; k++) begin
      if (req_log.size() > n) return;
      @(negedge clk);
    end
    check({name, "_req_timeout"}, 32'(req_log.size()), 32'(n + 1));
  endtask

  task automatic wait_ok(input string name, output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rom_ok) begin lat = cyc - req_cyc; break; end
    end
    if (lat < 0) check({name, "_ok_timeout"}, 32'(rom_ok), 32'd1);
  endtask

  task automatic wait_quiet();
    int q = 0;
    for (int k = 0; k < 300 && q < 3; k++) begin
      @(negedge clk);
      if (!busy && !sdram_req) q++; else q = 0;
    end
    if (q < 3) check("quiet_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [17:0]   addr;
    int            ack, g0, g1;
    logic [AW-1:0] exp_addr;
    int            exp_lat;
    logic [31:0]   exp_data;
  } vec_t;
  vec_t vt[5];

  initial begin
    int n0, lat;
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, lat;
    rst = 1'b1; inv = 1'b0; rom_cs = 1'b0; rom_addr = '0;
    // latency = ack delay + strobe spacings + 1 cycle to expose the fill
    vt[0] = '{18'h00404, 1, 1, 1, 22'h10404, 4, 32'hC3D4A1B2};
    vt[1] = '{18'h00406, 1, 1, 1, 22'h10406, 4, {mem(22'h10407), mem(22'h10406)}};
    vt[2] = '{18'h00404, 1, 1, 1, 22'h10404, 4, 32'hC3D4A1B2};
    vt[3] = '{18'h3FFFE, 2, 0, 1, 22'h4FFFE, 4, {mem(22'h4FFFF), mem(22'h4FFFE)}};
    vt[4] = '{18'h01230, 10, 5, 5, 22'h11230, 21, {mem(22'h11231), mem(22'h11230)}};

    cyc_wait(3);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_ok", 32'(rom_ok), 32'd0);
    check("rst_data", rom_data, 32'd0);
    rst = 1'b0; mon_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      n0 = req_log.size();
      ack_dly = vt[i].ack; d0 = vt[i].g0; d1 = vt[i].g1;
      rom_addr = vt[i].addr; rom_cs = 1'b1;
      wait_ok("vec", lat);
      check("vec_latency", 32'(lat), 32'(vt[i].exp_lat));
      check("vec_data", rom_data, vt[i].exp_data);
      check("vec_nreq", 32'(req_log.size() - n0), 32'd1);
      if (req_log.size() > n0) check("vec_sdram_addr", 32'(req_log[n0]), 32'(vt[i].exp_addr));
      cyc_wait(3);
      check("vec_hit_noreq", 32'(req_log.size() - n0), 32'd1);
    end

    // rom_addr moves between the two strobes
    ack_dly = 1; d0 = 1; d1 = 3;
    n0 = req_log.size();
    rom_addr = 18'h00404;
    wait_req(n0, "mid");
    cyc_wait(3);
    rom_addr = 18'h00800;
    wait_req(n0 + 1, "mid2");
    wait_ok("mid", lat);
    if (req_log.size() > n0 + 1) begin
      check("mid_first_addr", 32'(req_log[n0]), 32'h10404);
      check("mid_second_addr", 32'(req_log[n0 + 1]), 32'h10800);
    end
    check("mid_data", rom_data, {mem(22'h10801), mem(22'h10800)});

    // inv pulse while waiting for the first strobe
    ack_dly = 1; d0 = 3; d1 = 1;
    n0 = req_log.size();
    rom_addr = 18'h00A00;
    wait_req(n0, "inv");
    cyc_wait(2);
    inv = 1'b1;
    cyc_wait(1);
    inv = 1'b0;
    wait_req(n0 + 1, "inv2");
    if (req_log.size() > n0 + 1) check("inv_refetch_addr", 32'(req_log[n0 + 1]), 32'h10A00);
    wait_ok("inv", lat);
    check("inv_data", rom_data, {mem(22'h10A01), mem(22'h10A00)});

    // inv while hitting masks rom_ok and forces a refetch
    ack_dly = 1; d0 = 1; d1 = 1;
    cyc_wait(1);
    inv = 1'b1;
    @(negedge clk);
    check("inv_masks_ok", 32'(rom_ok), 32'd0);
    n0 = req_log.size();
    cyc_wait(1);
    inv = 1'b0;
    wait_req(n0, "inv_hit");
    wait_ok("inv_hit", lat);
    check("inv_hit_nreq", 32'(req_log.size() - n0), 32'd1);

    // rom_cs low: no ok, no new request even on a miss
    rom_cs = 1'b0;
    @(negedge clk);
    check("cs_low_ok", 32'(rom_ok), 32'd0);
    n0 = req_log.size();
    cyc_wait(1);
    rom_addr = 18'h00C00;
    cyc_wait(4);
    check("cs_low_noreq", 32'(req_log.size() - n0), 32'd0);

    // reset while in W1
    ack_dly = 1; d0 = 1; d1 = 3;
    rom_cs = 1'b1;
    wait_req(n0, "rst");
    cyc_wait(3);
    rst = 1'b1;
    #1;
    check("rst_mid_req", 32'(sdram_req), 32'd0);
    check("rst_mid_ok", 32'(rom_ok), 32'd0);
    check("rst_mid_addr", 32'(sdram_addr), 32'd0);
    cyc_wait(6);
    for (int k = 0; k < 50 && busy; k++) cyc_wait(1);
    check("rst_mid_responder_idle", 32'(busy), 32'd0);
    n0 = req_log.size();
    rst = 1'b0;
    wait_req(n0, "rst_refetch");
    if (req_log.size() > n0) check("rst_refetch_addr", 32'(req_log[n0]), 32'h10C00);
    wait_ok("rst_refetch", lat);
    check("rst_refetch_data", rom_data, {mem(22'h10C01), mem(22'h10C00)});

    // randomized traffic against the reference
    for (int it = 0; it < 80; it++) begin
      int r;
      ack_dly = $urandom_range(1, 3); d0 = $urandom_range(0, 2); d1 = $urandom_range(1, 2);
      r = $urandom_range(0, 9);
      if (r < 3)      rom_addr = 18'h00404;
      else if (r < 5) rom_addr = 18'h00406;
      else if (r < 6) rom_addr = 18'h00800;
      else begin
        rom_addr = 18'($urandom);
        rom_addr[0] = 1'b0;
      end
      rom_cs = ($urandom_range(0, 7) != 0);
      inv = ($urandom_range(0, 15) == 0);
      cyc_wait(1);
      inv = 1'b0;
      cyc_wait($urandom_range(0, 8));
    end
    rom_cs = 1'b0;
    wait_quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
